imu_quat_step: RTL and testbench
================================

// Module: imu_quat_step
// PURPOSE
//  Single attitude-integration step. Converts a gyro rate sample (wx,wy,wz) and timestep dt into a
//  small-angle Q15 delta quaternion, then Hamilton-multiplies previous attitude q_prev by it (q_prev ⊗ dq).
//  Single-clock, 3-stage pipeline; caller feeds q_out back as q_prev for the next sample.
// PARAMETERS
//  DT_SHIFT  20  right shift applied to w*dt to form the half-angle in Q15 (rate LSB/time-unit scaling)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   sample qualifier for wx/wy/wz/dt/q_prev
//  wx,wy,wz   in   16  signed angular rate, raw gyro counts
//  dt         in   32  unsigned timestep
//  q0p..q3p   in   16  signed Q15 previous quaternion (w,x,y,z)
//  dq0..dq3   out  16  signed Q15 registered delta quaternion (debug/observability)
//  r1..r4     out  32  signed Q30 product q_prev ⊗ dq (w,x,y,z)
//  q0n..q3n   out  16  signed Q15 product, r >>> 15 saturated
//  out_valid  out  1   r*/q*n hold a result for an in_valid sample
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): dq0=32767, dq1..dq3=0, r1..r4=0, q0n..q3n=0, all valid bits 0.
//  Clock enable: none. Pipeline advances every cycle; valid is a 3-deep shift of in_valid.
//  Stage1 (edge N):
//   v_i = sat16((w_i * $signed({1'b0,dt})) >>> DT_SHIFT), 49-bit signed product, arithmetic shift (floor).
//   dq1..3 = v_x, v_y, v_z.
//   dq0 = sat16(32767 - ((v_x²+v_y²+v_z²) >>> 16)), 2nd-order cos approximation.
//   q_prev registered alongside dq, so both operands stay aligned.
//  Stage2 (N+1): all 16 signed 16x16 -> 32-bit products registered.
//  Stage3 (N+2), with (a1,b1,c1,d1)=q_prev and (a2,b2,c2,d2)=dq:
//   r1 = a1a2 - b1b2 - c1c2 - d1d2
//   r2 = a1b2 + b1a2 + c1d2 - d1c2
//   r3 = a1c2 - b1d2 + c1a2 + d1b2
//   r4 = a1d2 + b1c2 - c1b2 + d1a2
//   Sum in 34 bits, saturate to 32-bit signed.
//   q*n = sat16(r >>> 15), floor, no rounding.
//  Latency: inputs sampled at edge N -> dq at N (visible after N), r/q*n/out_valid after edge N+2.
//   3 register stages total; throughput 1 sample/cycle.
//  Boundaries:
//   dt=0 or w=0 -> dq = identity (32767,0,0,0).
//   Negative w floors toward -inf.
//   Products/sums never wrap (saturate).
//   rst mid-stream flushes every stage to reset values the same cycle; no partial results emerge.
//  Identity decays by 1 LSB per step (32767²>>15 = 32766); renormalisation is the caller's job.
// STRUCTURE
//  Shared package: Q15_ONE=16'sd32767, sat16/sat32 functions, quaternion struct/typedef (4 x 16-bit).
//  Sub-module: quat_mult_pipe (stages 2-3, Hamilton product).
//  Delta generation (stage 1) stays inline in imu_quat_step.
// TESTING
//  1. rst=1 for 3 cycles -> dq=(32767,0,0,0), r*=0, out_valid=0.
//     Release with q_prev=(32767,0,0,0), w=0, dt=10000 ->
//     3 cycles later r1=1073676289, r2..r4=0, q0n=32766.
//  2. wx=15000, dt=10000, q_prev identity -> dq=(32767,143,0,0), r1=1073676289, r2=4685681, q1n=142.
//     Same with wy / wz -> value appears in dq2/r3 and dq3/r4 respectively.
//  3. wx=-15000, dt=10000 -> dq1=-144 (floor).
//     wx=32767, dt=32'hFFFFFFFF -> dq1=32767 (saturated), dq0=16384.
//  4. Feedback loop: q_prev <= q_out each cycle, wz=15000 for 20 cycles ->
//     q3n grows monotonically, no overflow, q0n non-increasing.
//     Compare each step to a bit-exact reference model.
//  5. Back-to-back distinct samples every cycle -> results appear in order with exact 3-cycle latency.
//     Assert rst mid-stream -> all outputs at reset values the next cycle, out_valid=0 until new samples propagate.
//  6. Saturation: q_prev=(-32768,-32768,-32768,-32768) times dq=(32767,32767,32767,32767) ->
//     r* match sat32 of the exact sums, no wrap.

Source files
------------

// File: rtl/imu_quat_step_pkg.sv
// Shared definitions for the attitude-integration step.
//   Q15_ONE : largest positive Q15 value, used as the quaternion "1.0"
//   quat_t  : packed quaternion, four signed Q15 components (w,x,y,z)
//   sat16   : clamp a signed 64-bit value to the signed 16-bit range
//   sat32   : clamp a signed 64-bit value to the signed 32-bit range
package imu_quat_step_pkg;

  localparam logic signed [15:0] Q15_ONE = 16'sd32767;

  typedef struct packed {
    logic signed [15:0] w;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } quat_t;

  function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767)
      return 16'sh7fff;
    else if (v < -64'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sd2147483647)
      return 32'sh7fffffff;
    else if (v < -64'sd2147483648)
      return 32'sh80000000;
    else
      return v[31:0];
  endfunction

endpackage

// File: rtl/quat_mult_pipe.sv
// Two-stage pipelined Hamilton product r = a (x) b of two Q15 quaternions.
//   clk, rst : clock and synchronous active-high reset (clears every stage)
//   vld_p0   : qualifier aligned with a/b
//   a, b     : Q15 operands (a = previous attitude, b = delta quaternion)
//   r1..r4   : Q30 product (w,x,y,z), saturated to signed 32 bits
//   qn       : Q15 product, each r >>> 15 (floor) saturated to 16 bits
//   vld_p2   : qualifier aligned with r1..r4 / qn
module quat_mult_pipe
  import imu_quat_step_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               vld_p0,
  input  quat_t              a,
  input  quat_t              b,
  output logic signed [31:0] r1,
  output logic signed [31:0] r2,
  output logic signed [31:0] r3,
  output logic signed [31:0] r4,
  output quat_t              qn,
  output logic               vld_p2
);

  function automatic logic signed [31:0] mul16(input logic signed [15:0] x,
                                               input logic signed [15:0] y);
    logic signed [31:0] xe;
    logic signed [31:0] ye;
    xe = {{16{x[15]}}, x};
    ye = {{16{y[15]}}, y};
    return xe * ye;
  endfunction

  function automatic logic signed [33:0] ext34(input logic signed [31:0] x);
    return {{2{x[31]}}, x};
  endfunction

  function automatic logic signed [15:0] q15_of(input logic signed [31:0] r);
    logic signed [31:0] t;
    t = r >>> 15;
    return sat16({{32{t[31]}}, t});
  endfunction

  logic signed [15:0] av [4];
  logic signed [15:0] bv [4];

  assign av[0] = a.w;
  assign av[1] = a.x;
  assign av[2] = a.y;
  assign av[3] = a.z;
  assign bv[0] = b.w;
  assign bv[1] = b.x;
  assign bv[2] = b.y;
  assign bv[3] = b.z;

  // ---- stage 2: all sixteen partial products ----
  logic signed [31:0] prod_p1 [4][4];
  logic               vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          prod_p1[i][j] <= '0;
    end else begin
      vld_p1 <= vld_p0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          prod_p1[i][j] <= mul16(av[i], bv[j]);
    end
  end

  // ---- stage 3: Hamilton sums (34-bit headroom), saturation, Q15 rescale ----
  logic signed [33:0] sum [4];

  always_comb begin
    sum[0] = ext34(prod_p1[0][0]) - ext34(prod_p1[1][1])
           - ext34(prod_p1[2][2]) - ext34(prod_p1[3][3]);
    sum[1] = ext34(prod_p1[0][1]) + ext34(prod_p1[1][0])
           + ext34(prod_p1[2][3]) - ext34(prod_p1[3][2]);
    sum[2] = ext34(prod_p1[0][2]) - ext34(prod_p1[1][3])
           + ext34(prod_p1[2][0]) + ext34(prod_p1[3][1]);
    sum[3] = ext34(prod_p1[0][3]) + ext34(prod_p1[1][2])
           - ext34(prod_p1[2][1]) + ext34(prod_p1[3][0]);
  end

  logic signed [31:0] rsat [4];

  always_comb begin
    for (int k = 0; k < 4; k++)
      rsat[k] = sat32({{30{sum[k][33]}}, sum[k]});
  end

  logic signed [31:0] r_p2 [4];
  quat_t              qn_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      qn_p2  <= '0;
      for (int k = 0; k < 4; k++)
        r_p2[k] <= '0;
    end else begin
      vld_p2 <= vld_p1;
      qn_p2  <= '{w: q15_of(rsat[0]), x: q15_of(rsat[1]),
                  y: q15_of(rsat[2]), z: q15_of(rsat[3])};
      for (int k = 0; k < 4; k++)
        r_p2[k] <= rsat[k];
    end
  end

  assign r1 = r_p2[0];
  assign r2 = r_p2[1];
  assign r3 = r_p2[2];
  assign r4 = r_p2[3];
  assign qn = qn_p2;

endmodule

// File: rtl/imu_quat_step.sv
// One attitude-integration step: gyro rate (wx,wy,wz) and timestep dt are
// turned into a small-angle Q15 delta quaternion dq, then q_prev (x) dq is
// formed by a two-stage Hamilton multiplier. Three register stages in total.
//   clk, rst        : clock, synchronous active-high reset (flushes all stages)
//   in_valid        : qualifies wx/wy/wz/dt/q0p..q3p
//   wx, wy, wz      : signed raw gyro counts
//   dt              : unsigned timestep
//   q0p..q3p        : previous attitude, signed Q15 (w,x,y,z)
//   dq0..dq3        : registered delta quaternion, signed Q15
//   r1..r4          : Q30 product q_prev (x) dq, saturated to 32 bits
//   q0n..q3n        : Q15 product, r >>> 15 saturated
//   out_valid       : r1..r4 / q0n..q3n belong to an in_valid sample
module imu_quat_step
  import imu_quat_step_pkg::*;
#(
  parameter int DT_SHIFT = 20
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] wx,
  input  logic signed [15:0] wy,
  input  logic signed [15:0] wz,
  input  logic        [31:0] dt,
  input  logic signed [15:0] q0p,
  input  logic signed [15:0] q1p,
  input  logic signed [15:0] q2p,
  input  logic signed [15:0] q3p,
  output logic signed [15:0] dq0,
  output logic signed [15:0] dq1,
  output logic signed [15:0] dq2,
  output logic signed [15:0] dq3,
  output logic signed [31:0] r1,
  output logic signed [31:0] r2,
  output logic signed [31:0] r3,
  output logic signed [31:0] r4,
  output logic signed [15:0] q0n,
  output logic signed [15:0] q1n,
  output logic signed [15:0] q2n,
  output logic signed [15:0] q3n,
  output logic               out_valid
);

  // Half-angle in Q15: rate * dt, scaled down by DT_SHIFT. dt is treated as
  // a non-negative 33-bit signed operand so the 49-bit product is exact and
  // the arithmetic shift floors toward -inf.
  function automatic logic signed [15:0] half_angle(input logic signed [15:0] w,
                                                    input logic signed [48:0] d);
    logic signed [48:0] we;
    logic signed [48:0] prod;
    logic signed [48:0] sh;
    we   = {{33{w[15]}}, w};
    prod = we * d;
    sh   = prod >>> DT_SHIFT;
    return sat16({{15{sh[48]}}, sh});
  endfunction

  function automatic logic signed [33:0] sq34(input logic signed [15:0] v);
    logic signed [33:0] ve;
    ve = {{18{v[15]}}, v};
    return ve * ve;
  endfunction

  logic signed [48:0] dt_e;
  logic signed [15:0] vx;
  logic signed [15:0] vy;
  logic signed [15:0] vz;
  logic signed [33:0] vsum;
  logic signed [33:0] vsh;
  logic signed [63:0] d0_wide;
  logic signed [15:0] d0;

  assign dt_e = {17'd0, dt};
  assign vx   = half_angle(wx, dt_e);
  assign vy   = half_angle(wy, dt_e);
  assign vz   = half_angle(wz, dt_e);

  // Second-order cosine: 1 - |v|^2/2 with v in Q15 -> |v|^2 is Q30, and
  // halving plus the Q30->Q15 rescale together are a shift by 16.
  assign vsum    = sq34(vx) + sq34(vy) + sq34(vz);
  assign vsh     = vsum >>> 16;
  assign d0_wide = {{48{Q15_ONE[15]}}, Q15_ONE} - {{30{vsh[33]}}, vsh};
  assign d0      = sat16(d0_wide);

  // ---- stage 1: delta quaternion and the aligned previous attitude ----
  quat_t dq_p0;
  quat_t qp_p0;
  logic  vld_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      dq_p0  <= '{w: Q15_ONE, x: '0, y: '0, z: '0};
      qp_p0  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      dq_p0  <= '{w: d0, x: vx, y: vy, z: vz};
      qp_p0  <= '{w: q0p, x: q1p, y: q2p, z: q3p};
      vld_p0 <= in_valid;
    end
  end

  quat_t qn;

  quat_mult_pipe u_mult (
    .clk    (clk),
    .rst    (rst),
    .vld_p0 (vld_p0),
    .a      (qp_p0),
    .b      (dq_p0),
    .r1     (r1),
    .r2     (r2),
    .r3     (r3),
    .r4     (r4),
    .qn     (qn),
    .vld_p2 (out_valid)
  );

  assign dq0 = dq_p0.w;
  assign dq1 = dq_p0.x;
  assign dq2 = dq_p0.y;
  assign dq3 = dq_p0.z;
  assign q0n = qn.w;
  assign q1n = qn.x;
  assign q2n = qn.y;
  assign q3n = qn.z;

endmodule

// File: tb/tb_imu_quat_step.sv
// Directed bench for imu_quat_step: reset state, single-axis deltas,
// floor/saturation corners, closed-loop integration against a bit-exact
// integer model, back-to-back pipelining with a mid-stream reset, and
// Hamilton-sum saturation.
module tb_imu_quat_step;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] wx, wy, wz;
  logic        [31:0] dt;
  logic signed [15:0] q0p, q1p, q2p, q3p;
  logic signed [15:0] dq0, dq1, dq2, dq3;
  logic signed [31:0] r1, r2, r3, r4;
  logic signed [15:0] q0n, q1n, q2n, q3n;
  logic               out_valid;

  imu_quat_step #(.DT_SHIFT(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .wx(wx), .wy(wy), .wz(wz), .dt(dt),
    .q0p(q0p), .q1p(q1p), .q2p(q2p), .q3p(q3p),
    .dq0(dq0), .dq1(dq1), .dq2(dq2), .dq3(dq3),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .q0n(q0n), .q1n(q1n), .q2n(q2n), .q3n(q3n),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  longint m_dq [4];
  longint m_r  [4];
  longint m_qn [4];
  logic signed [63:0] o_dq [4];
  logic signed [63:0] o_r  [4];
  logic signed [63:0] o_qn [4];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic longint msat(input longint x, input longint lo, input longint hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Integer reference: small-angle delta then quaternion product.
  function automatic void model(input longint w0, w1, w2, dtv, a0, a1, a2, a3);
    longint v0, v1, v2;
    longint a [4];
    longint b [4];
    longint s [4];
    v0 = msat((w0 * dtv) >>> 20, -32768, 32767);
    v1 = msat((w1 * dtv) >>> 20, -32768, 32767);
    v2 = msat((w2 * dtv) >>> 20, -32768, 32767);
    b[0] = msat(32767 - ((v0 * v0 + v1 * v1 + v2 * v2) >>> 16), -32768, 32767);
    b[1] = v0; b[2] = v1; b[3] = v2;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    s[0] = a[0]*b[0] - a[1]*b[1] - a[2]*b[2] - a[3]*b[3];
    s[1] = a[0]*b[1] + a[1]*b[0] + a[2]*b[3] - a[3]*b[2];
    s[2] = a[0]*b[2] - a[1]*b[3] + a[2]*b[0] + a[3]*b[1];
    s[3] = a[0]*b[3] + a[1]*b[2] - a[2]*b[1] + a[3]*b[0];
    for (int k = 0; k < 4; k++) begin
      m_dq[k] = b[k];
      m_r[k]  = msat(s[k], -64'sd2147483648, 64'sd2147483647);
      m_qn[k] = msat(m_r[k] >>> 15, -32768, 32767);
    end
  endfunction

  task automatic drive(input longint w0, w1, w2, dtv, a0, a1, a2, a3);
    wx  = w0[15:0];
    wy  = w1[15:0];
    wz  = w2[15:0];
    dt  = dtv[31:0];
    q0p = a0[15:0];
    q1p = a1[15:0];
    q2p = a2[15:0];
    q3p = a3[15:0];
  endtask

  task automatic cap_dq;
    o_dq[0] = dq0; o_dq[1] = dq1; o_dq[2] = dq2; o_dq[3] = dq3;
  endtask

  task automatic cap_r;
    o_r[0] = r1; o_r[1] = r2; o_r[2] = r3; o_r[3] = r4;
    o_qn[0] = q0n; o_qn[1] = q1n; o_qn[2] = q2n; o_qn[3] = q3n;
  endtask

  // One isolated sample: dq checked after the first edge, result after the third.
  task automatic run_one(input string tag, input longint w0, w1, w2, dtv,
                         input longint a0, a1, a2, a3);
    model(w0, w1, w2, dtv, a0, a1, a2, a3);
    drive(w0, w1, w2, dtv, a0, a1, a2, a3);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    cap_dq;
    for (int k = 0; k < 4; k++)
      check($sformatf("%s.dq%0d", tag, k), o_dq[k], m_dq[k]);
    tick;
    tick;
    cap_r;
    check({tag, ".out_valid"}, {63'd0, out_valid}, 64'sd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s.r%0d", tag, k + 1), o_r[k], m_r[k]);
      check($sformatf("%s.q%0dn", tag, k), o_qn[k], m_qn[k]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".dq0"}, dq0, 64'sd32767);
    check({tag, ".dq1"}, dq1, 64'sd0);
    check({tag, ".dq2"}, dq2, 64'sd0);
    check({tag, ".dq3"}, dq3, 64'sd0);
    check({tag, ".r1"}, r1, 64'sd0);
    check({tag, ".r2"}, r2, 64'sd0);
    check({tag, ".r3"}, r3, 64'sd0);
    check({tag, ".r4"}, r4, 64'sd0);
    check({tag, ".q0n"}, q0n, 64'sd0);
    check({tag, ".q1n"}, q1n, 64'sd0);
    check({tag, ".q2n"}, q2n, 64'sd0);
    check({tag, ".q3n"}, q3n, 64'sd0);
    check({tag, ".out_valid"}, {63'd0, out_valid}, 64'sd0);
  endtask

  longint s_w  [6];
  longint s_dt [6];
  longint s_q  [6][4];
  longint x_dq [6][4];
  longint x_r  [6][4];
  longint x_qn [6][4];
  longint qa   [4];
  longint prev0, prev3;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick;
    check_reset_state("reset");

    // Identity in, zero rate: product decays by one LSB.
    rst = 1'b0;
    run_one("ident", 0, 0, 0, 10000, 32767, 0, 0, 0);
    check("ident.r1_hand", o_r[0], 64'sd1073676289);
    check("ident.q0n_hand", o_qn[0], 64'sd32766);
    check("ident.dq0_hand", o_dq[0], 64'sd32767);

    // Single-axis rates.
    run_one("wx", 15000, 0, 0, 10000, 32767, 0, 0, 0);
    check("wx.dq0_hand", o_dq[0], 64'sd32767);
    check("wx.dq1_hand", o_dq[1], 64'sd143);
    check("wx.r1_hand", o_r[0], 64'sd1073676289);
    check("wx.r2_hand", o_r[1], 64'sd4685681);
    check("wx.q1n_hand", o_qn[1], 64'sd142);
    run_one("wy", 0, 15000, 0, 10000, 32767, 0, 0, 0);
    check("wy.dq2_hand", o_dq[2], 64'sd143);
    check("wy.r3_hand", o_r[2], 64'sd4685681);
    check("wy.q2n_hand", o_qn[2], 64'sd142);
    run_one("wz", 0, 0, 15000, 10000, 32767, 0, 0, 0);
    check("wz.dq3_hand", o_dq[3], 64'sd143);
    check("wz.r4_hand", o_r[3], 64'sd4685681);
    check("wz.q3n_hand", o_qn[3], 64'sd142);

    // Floor on negative rate, then saturated half-angle.
    run_one("negw", -15000, 0, 0, 10000, 32767, 0, 0, 0);
    check("negw.dq1_hand", o_dq[1], -64'sd144);
    check("negw.r2_hand", o_r[1], -64'sd4718448);
    check("negw.q1n_hand", o_qn[1], -64'sd144);
    run_one("satw", 32767, 0, 0, 64'd4294967295, 32767, 0, 0, 0);
    check("satw.dq1_hand", o_dq[1], 64'sd32767);
    check("satw.dq0_hand", o_dq[0], 64'sd16384);
    check("satw.r1_hand", o_r[0], 64'sd536854528);
    check("satw.q0n_hand", o_qn[0], 64'sd16383);

    // Hamilton sums beyond 32 bits clamp instead of wrapping.
    run_one("satp", 32767, 32767, 32767, 64'd4294967295, -32768, -32768, -32768, -32768);
    check("satp.dq0_hand", o_dq[0], -64'sd16382);
    check("satp.r1_hand", o_r[0], 64'sd2147483647);
    check("satp.r2_hand", o_r[1], -64'sd536903680);
    check("satp.q0n_hand", o_qn[0], 64'sd32767);
    check("satp.q1n_hand", o_qn[1], -64'sd16385);
    run_one("satn", 32767, 32767, 32767, 64'd4294967295, 32767, 32767, 32767, 32767);
    check("satn.r1_hand", o_r[0], -64'sd2147483648);
    check("satn.q0n_hand", o_qn[0], -64'sd32768);
    check("satn.r2_hand", o_r[1], 64'sd536887295);
    check("satn.q1n_hand", o_qn[1], 64'sd16384);

    // Closed-loop integration about z.
    qa = '{32767, 0, 0, 0};
    prev0 = 32767;
    prev3 = -1;
    for (int s = 0; s < 20; s++) begin
      run_one($sformatf("fb%0d", s), 0, 0, 15000, 10000, qa[0], qa[1], qa[2], qa[3]);
      check($sformatf("fb%0d.q3n_rises", s), {63'd0, (o_qn[3] > prev3)}, 64'sd1);
      check($sformatf("fb%0d.q0n_nonrising", s), {63'd0, (o_qn[0] <= prev0)}, 64'sd1);
      prev0 = o_qn[0];
      prev3 = o_qn[3];
      for (int k = 0; k < 4; k++) qa[k] = o_qn[k];
    end

    // Back-to-back samples, one per cycle.
    s_w  = '{1000, -2000, 3000, 15000, -15000, 32767};
    s_dt = '{10000, 20000, 5000, 10000, 10000, 100000};
    s_q  = '{'{32767, 0, 0, 0}, '{23170, 23170, 0, 0}, '{0, 0, 32767, 0},
             '{-16384, 8192, -4096, 2048}, '{32767, -32768, 100, -100},
             '{1000, 2000, 3000, 4000}};
    for (int i = 0; i < 6; i++) begin
      model(s_w[i], s_w[i] / 2, -s_w[i] / 3, s_dt[i],
            s_q[i][0], s_q[i][1], s_q[i][2], s_q[i][3]);
      for (int k = 0; k < 4; k++) begin
        x_dq[i][k] = m_dq[k];
        x_r[i][k]  = m_r[k];
        x_qn[i][k] = m_qn[k];
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        drive(s_w[i], s_w[i] / 2, -s_w[i] / 3, s_dt[i],
              s_q[i][0], s_q[i][1], s_q[i][2], s_q[i][3]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick;
      cap_dq;
      cap_r;
      check($sformatf("b2b%0d.out_valid", i), {63'd0, out_valid}, (i >= 2) ? 64'sd1 : 64'sd0);
      if (i < 6)
        for (int k = 0; k < 4; k++)
          check($sformatf("b2b%0d.dq%0d", i, k), o_dq[k], x_dq[i][k]);
      if (i >= 2)
        for (int k = 0; k < 4; k++) begin
          check($sformatf("b2b%0d.r%0d", i - 2, k + 1), o_r[k], x_r[i - 2][k]);
          check($sformatf("b2b%0d.q%0dn", i - 2, k), o_qn[k], x_qn[i - 2][k]);
        end
    end
    tick;
    check("b2b.drain_out_valid", {63'd0, out_valid}, 64'sd0);

    // Reset while three samples are in flight.
    for (int i = 0; i < 3; i++) begin
      drive(s_w[i], s_w[i] / 2, -s_w[i] / 3, s_dt[i],
            s_q[i][0], s_q[i][1], s_q[i][2], s_q[i][3]);
      in_valid = 1'b1;
      if (i == 2) rst = 1'b1;
      tick;
    end
    check_reset_state("midrst");
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("midrst.after%0d.out_valid", i), {63'd0, out_valid}, 64'sd0);
    end
    run_one("recover", s_w[3], s_w[3] / 2, -s_w[3] / 3, s_dt[3],
            s_q[3][0], s_q[3][1], s_q[3][2], s_q[3][3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
